// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator and the counter firmware:
// position width, direction codes and the A/B encoding.
package quad_pkg;

  localparam int POS_W = 14;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Up-count order of {A,B} is 00,10,11,01.
  function automatic logic [1:0] quad_encode(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

endpackage

// File: rtl/quad_index.sv
// Revolution counter and index pulse stretcher; tracks position modulo cpr
// and emits a ZLEN-clock Z pulse whenever a step lands on rev 0.
module quad_index
  import quad_pkg::*;
#(
  parameter int W    = POS_W,
  parameter int ZLEN = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         dir,
  input  logic [W-1:0] cpr,
  output logic         Z
);

  localparam int ZW = $clog2(ZLEN + 1);

  logic [W-1:0]  rev;
  logic [W-1:0]  rev_next;
  logic [ZW-1:0] ztimer;
  logic          index_event;

  always_comb begin
    rev_next    = rev;
    index_event = 1'b0;
    if (step && (cpr != '0)) begin
      if (dir == DIR_UP) begin
        if ((rev == cpr - W'(1)) || (rev >= cpr)) rev_next = '0;
        else                                      rev_next = rev + W'(1);
      end else begin
        if (rev == '0)       rev_next = cpr - W'(1);
        else if (rev >= cpr) rev_next = '0;
        else                 rev_next = rev - W'(1);
      end
      index_event = (rev_next == '0);
    end
  end

  // Z is high for exactly the clocks in which ztimer holds ZLEN..1.
  always_ff @(posedge clk) begin
    if (reset) begin
      rev    <= '0;
      ztimer <= '0;
      Z      <= 1'b0;
    end else begin
      rev <= rev_next;
      if (index_event) begin
        ztimer <= ZW'(ZLEN);
        Z      <= 1'b1;
      end else begin
        if (ztimer != '0) ztimer <= ztimer - ZW'(1);
        Z <= (ztimer > ZW'(1));
      end
    end
  end

endmodule

// File: rtl/quad_gen.sv
// Quadrature generator: walks pos toward target one count per eligible
// clock, honouring a dwell between steps, and drives A/B/Z from it.
module quad_gen
  import quad_pkg::*;
#(
  parameter int W       = POS_W,
  parameter int DWELL_W = 8,
  parameter int ZLEN    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [W-1:0]       target,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [W-1:0]       cpr,
  output logic               A,
  output logic               B,
  output logic               Z,
  output logic [W-1:0]       pos,
  output logic               busy
);

  logic [W-1:0]       d;
  logic [W-1:0]       pos_next;
  logic [DWELL_W-1:0] timer;
  logic               step;
  logic               dir;

  // Half-range difference has its MSB set and therefore steps down.
  always_comb begin
    d        = target - pos;
    step     = (timer == '0) && (d != '0);
    dir      = d[W-1] ? DIR_DN : DIR_UP;
    pos_next = pos;
    if (step) pos_next = (dir == DIR_DN) ? pos - W'(1) : pos + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos   <= '0;
      timer <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      pos <= pos_next;
      if (step)             timer <= dwell;
      else if (timer != '0) timer <= timer - DWELL_W'(1);
      {A, B} <= quad_encode(pos_next[1:0]);
      busy   <= (target != pos_next);
    end
  end

  quad_index #(
    .W    (W),
    .ZLEN (ZLEN)
  ) u_index (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .dir   (dir),
    .cpr   (cpr),
    .Z     (Z)
  );

endmodule
